pipe_fixed_point_sqrt: RTL and testbench

Fully pipelined, parameterizable fixed-point square-root unit. It accepts one signed fixed-point operand per clock and produces its square root in a different signed fixed-point format after a fixed latency. The rounding mode is selectable, and out-of-range results saturate with a flag. It is a leaf arithmetic block for the fixed-point datapath library, alongside the other `pipe_` operators.

---
 rtl/pipe_fixed_point_sqrt.sv | 137 +++++++++++++
 tb/tb_pipe_fixed_point_sqrt.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/pipe_fixed_point_sqrt.sv
// Fully pipelined fixed-point square root using a restoring bit-serial integer sqrt.
// One operand enters per clock. The result leaves WOI+WOF+2 clocks later, rounded or
// truncated to WOF fraction bits and saturated to the output format.
module pipe_fixed_point_sqrt #(
  parameter int WII   = 8,
  parameter int WIF   = 8,
  parameter int WOI   = 8,
  parameter int WOF   = 8,
  parameter int ROUND = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WII+WIF-1:0]   in,
  output logic [WOI+WOF-1:0]   out,
  output logic                 overflow
);

  localparam int WI   = WII + WIF;
  localparam int WO   = WOI + WOF;
  // Root fraction bits: one guard bit when rounding.
  localparam int F    = WOF + ((ROUND != 0) ? 1 : 0);
  // Integer root bits needed for any input magnitude: ceil((WII-1)/2)+1.
  localparam int RI   = WII / 2 + 1;
  localparam int NB   = RI + F;
  // Iteration stages are fixed by the latency. Each stage resolves BPS root bits.
  // The root is widened with leading integer bits up to S*BPS. Those bits are
  // always zero, so they do not change the value.
  localparam int S    = WOI + WOF;
  localparam int BPS  = (NB + S - 1) / S;
  localparam int NBP  = S * BPS;
  localparam int RADW = 2 * NBP;
  localparam int REMW = NBP + 2;
  localparam int SHL  = (2 * F > WIF) ? 2 * F - WIF : 0;
  localparam int SHR  = (2 * F > WIF) ? 0 : WIF - 2 * F;
  localparam int CW   = ((NBP > WO) ? NBP : WO) + 2;

  localparam logic [WO-1:0] MAX = {1'b0, {(WO-1){1'b1}}};

  typedef struct packed {
    logic [RADW-1:0] rad;
    logic [REMW-1:0] rem;
    logic [NBP-1:0]  root;
  } iter_t;

  // BPS restoring iterations. Each one consumes the top two radicand bits and
  // produces one root bit.
  function automatic iter_t sqrt_step(input logic [RADW-1:0] rad,
                                      input logic [REMW-1:0] rem,
                                      input logic [NBP-1:0]  root);
    iter_t r;
    logic [REMW-1:0] cand;
    logic [REMW-1:0] trial;
    r.rad  = rad;
    r.rem  = rem;
    r.root = root;
    for (int unsigned b = 0; b < BPS; b++) begin
      cand  = {r.rem[REMW-3:0], r.rad[RADW-1 -: 2]};
      trial = {r.root, 2'b01};
      r.rad = r.rad << 2;
      if (cand >= trial) begin
        r.rem  = cand - trial;
        r.root = {r.root[NBP-2:0], 1'b1};
      end else begin
        r.rem  = cand;
        r.root = {r.root[NBP-2:0], 1'b0};
      end
    end
    return r;
  endfunction

  logic [RADW-1:0] rad0;
  logic [RADW-1:0] rad0_q;
  logic [S:0]      neg_q;
  iter_t           st_q [1:S];
  iter_t           nxt  [1:S];
  logic [CW-1:0]   rounded;
  logic [WO-1:0]   out_d;
  logic            ovf_d;

  // Align |in| so that the radicand has exactly 2*F fraction bits. A negative
  // input feeds a zero radicand.
  always_comb begin
    rad0 = '0;
    if (!in[WI-1]) begin
      if (SHL > 0) rad0 = RADW'(in[WI-2:0]) << SHL;
      else         rad0 = RADW'(in[WI-2:0] >> SHR);
    end
  end

  // Combinational work for each root-bit stage.
  always_comb begin
    nxt[1] = sqrt_step(rad0_q, '0, '0);
    for (int unsigned s = 2; s <= S; s++) begin
      nxt[s] = sqrt_step(st_q[s-1].rad, st_q[s-1].rem, st_q[s-1].root);
    end
  end

  // Pipeline registers: the aligned radicand and sign, then one register per iteration stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rad0_q <= '0;
      neg_q  <= '0;
      for (int unsigned s = 1; s <= S; s++) st_q[s] <= '0;
    end else begin
      rad0_q <= rad0;
      neg_q  <= {neg_q[S-1:0], in[WI-1]};
      for (int unsigned s = 1; s <= S; s++) st_q[s] <= nxt[s];
    end
  end

  // Round by adding in the guard bit and then dropping it. Then clamp negatives
  // and saturate above MAX.
  always_comb begin
    rounded = CW'(st_q[S].root);
    if (ROUND != 0) rounded = (rounded + CW'(1)) >> 1;
    out_d = WO'(rounded);
    ovf_d = 1'b0;
    if (neg_q[S]) begin
      out_d = '0;
    end else if (rounded > CW'(MAX)) begin
      out_d = MAX;
      ovf_d = 1'b1;
    end
  end

  // Output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out      <= '0;
      overflow <= 1'b0;
    end else begin
      out      <= out_d;
      overflow <= ovf_d;
    end
  end

endmodule

// File: tb/tb_pipe_fixed_point_sqrt.sv
// Directed and streaming checks for pipe_fixed_point_sqrt.
// There are three instances: Q9.10 with rounding, Q9.10 with truncation, and a
// Q3.10 output with rounding that exercises saturation.
module tb_pipe_fixed_point_sqrt;

  localparam int L  = 21;
  localparam int LS = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [18:0] din = '0;
  logic [18:0] out_r1, out_r0;
  logic [12:0] out_s;
  logic        ovf_r1, ovf_r0, ovf_s;
  int          total = 0;
  int          bad   = 0;
  logic [18:0] sv [40];
  logic [18:0] rv [25];
  logic [31:0] m;

  always #5 clk = ~clk;

  pipe_fixed_point_sqrt #(.WII(9), .WIF(10), .WOI(9), .WOF(10), .ROUND(1)) u_r1 (
    .clk(clk), .rst(rst), .in(din), .out(out_r1), .overflow(ovf_r1));
  pipe_fixed_point_sqrt #(.WII(9), .WIF(10), .WOI(9), .WOF(10), .ROUND(0)) u_r0 (
    .clk(clk), .rst(rst), .in(din), .out(out_r0), .overflow(ovf_r0));
  pipe_fixed_point_sqrt #(.WII(9), .WIF(10), .WOI(3), .WOF(10), .ROUND(1)) u_sat (
    .clk(clk), .rst(rst), .in(din), .out(out_s), .overflow(ovf_s));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Hold an operand until every pipeline is full of it, then check all three instances.
  task automatic hold_chk(input string tag, input logic [18:0] v, input logic [31:0] e1,
                          input logic [31:0] e0, input logic [31:0] es, input logic [31:0] eso);
    din = v;
    repeat (L + 1) step();
    chk({tag, "_r1"}, 32'(out_r1), e1);
    chk({tag, "_r1_ovf"}, 32'(ovf_r1), 32'd0);
    chk({tag, "_r0"}, 32'(out_r0), e0);
    chk({tag, "_r0_ovf"}, 32'(ovf_r0), 32'd0);
    chk({tag, "_sat"}, 32'(out_s), es);
    chk({tag, "_sat_ovf"}, 32'(ovf_s), eso);
  endtask

  // Reference: exact integer sqrt of the scaled operand, then round and saturate.
  // Bit 31 carries the overflow flag.
  function automatic logic [31:0] model(input logic [18:0] v, input int rnd, input int woi);
    longint unsigned x, r, mx;
    logic [31:0] res;
    res = '0;
    if (v[18]) return res;
    x = 64'(v) << (2 * (10 + rnd) - 10);
    r = 64'($rtoi($sqrt(real'(x))));
    while (r * r > x) r--;
    while ((r + 1) * (r + 1) <= x) r++;
    if (rnd != 0) r = (r + 1) >> 1;
    mx = (64'd1 << (woi + 10 - 1)) - 1;
    if (r > mx) begin
      res[30:0] = 31'(mx);
      res[31]   = 1'b1;
    end else begin
      res[30:0] = 31'(r);
    end
    return res;
  endfunction

  initial begin
    #2;
    chk("reset_r1", 32'(out_r1), 32'd0);
    chk("reset_r1_ovf", 32'(ovf_r1), 32'd0);
    chk("reset_sat", 32'(out_s), 32'd0);
    step();
    step();
    rst = 1'b0;

    // One-cycle pulse of 4.0 surrounded by zeros pins down the latency.
    din = 19'h01000;
    step();
    din = '0;
    repeat (L - 2) step();
    chk("lat_early", 32'(out_r1), 32'd0);
    step();
    chk("lat_exact", 32'(out_r1), 32'h800);
    chk("lat_exact_ovf", 32'(ovf_r1), 32'd0);
    step();
    chk("lat_after", 32'(out_r1), 32'd0);

    hold_chk("sq4",    19'h01000, 32'h800,  32'h800,  32'h800, 32'd0);
    hold_chk("sq1",    19'h00400, 32'h400,  32'h400,  32'h400, 32'd0);
    hold_chk("two",    19'h00800, 32'd1448, 32'd1448, 32'd1448, 32'd0);
    hold_chk("three",  19'h00C00, 32'd1774, 32'd1773, 32'd1774, 32'd0);
    hold_chk("zero",   19'h00000, 32'd0,    32'd0,    32'd0,   32'd0);
    hold_chk("maxpos", 19'h3FFFF, 32'h4000, 32'h3FFF, 32'hFFF, 32'd1);
    hold_chk("neg1",   19'h7FFFF, 32'd0,    32'd0,    32'd0,   32'd0);
    hold_chk("negmin1",19'h40001, 32'd0,    32'd0,    32'd0,   32'd0);
    hold_chk("negmin", 19'h40000, 32'd0,    32'd0,    32'd0,   32'd0);
    hold_chk("sixteen",19'h04000, 32'h1000, 32'h1000, 32'hFFF, 32'd1);
    hold_chk("nine",   19'h02400, 32'hC00,  32'hC00,  32'hC00, 32'd0);
    hold_chk("rndsat", 19'h03FFF, 32'h1000, 32'hFFF,  32'hFFF, 32'd1);

    // Back-to-back random operands, both signs, no idle cycles.
    for (int i = 0; i < 40; i++) sv[i] = 19'($urandom_range(0, 32'h7FFFF));
    sv[3] = 19'h7FF00;
    sv[4] = 19'h3FFFF;
    sv[5] = 19'h00001;
    for (int c = 0; c < 40 + L; c++) begin
      if (c >= L) begin
        m = model(sv[c-L], 1, 9);
        chk("stream_r1", 32'(out_r1), 32'(m[18:0]));
        chk("stream_r1_ovf", 32'(ovf_r1), 32'(m[31]));
        m = model(sv[c-L], 0, 9);
        chk("stream_r0", 32'(out_r0), 32'(m[18:0]));
      end
      if (c >= LS && c - LS < 40) begin
        m = model(sv[c-LS], 1, 3);
        chk("stream_sat", 32'(out_s), 32'(m[12:0]));
        chk("stream_sat_ovf", 32'(ovf_s), 32'(m[31]));
      end
      din = (c < 40) ? sv[c] : '0;
      step();
    end

    // Reset arrives mid-stream between clock edges.
    for (int i = 0; i < 25; i++) begin
      rv[i] = 19'($urandom_range(32'h00400, 32'h3FFFF));
      din = rv[i];
      step();
    end
    m = model(rv[25-L], 1, 9);
    chk("pre_rst_r1", 32'(out_r1), 32'(m[18:0]));
    din = 19'h01000;
    #3;
    rst = 1'b1;
    #1;
    chk("async_rst_r1", 32'(out_r1), 32'd0);
    chk("async_rst_r1_ovf", 32'(ovf_r1), 32'd0);
    chk("async_rst_sat", 32'(out_s), 32'd0);
    chk("async_rst_sat_ovf", 32'(ovf_s), 32'd0);
    repeat (3) step();
    chk("rst_hold_r1", 32'(out_r1), 32'd0);
    rst = 1'b0;
    for (int k = 1; k <= L; k++) begin
      step();
      chk("post_rst_r1", 32'(out_r1), (k == L) ? 32'h800 : 32'd0);
      chk("post_rst_sat", 32'(out_s), (k >= LS) ? 32'h800 : 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
